// File: rtl/uart_tx_buf.sv
// uart_tx_buf: UART transmitter fed from a small word FIFO, with runtime
// parity, stop-bit and bit-period configuration latched per frame.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   S_IDLE   | line high, waiting for a buffered word
//   S_START  | start bit (line low)
//   S_DATA   | data bits, LSB first
//   S_PARITY | parity bit (only when parity was enabled at frame start)
//   S_STOP   | one or two stop bits (line high)
module uart_tx_buf #(
    parameter int DATA_WIDTH     = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     P_DATA,
    input  logic                      Data_Valid,
    output logic                      ready,
    input  logic                      parity_enable,
    input  logic                      parity_type,
    input  logic                      two_stop,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      TX_OUT,
    output logic                      busy,
    output logic                      overflow
);

    localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = AW + 1;
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [AW-1:0]             PTR_ONE  = AW'(1);
    localparam logic [CNT_W-1:0]          CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]          FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [IDX_W-1:0]          IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0]          LAST_IDX = IDX_W'(DATA_WIDTH - 1);
    localparam logic [PRESCALE_WIDTH-1:0] PRE_ONE  = PRESCALE_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [DATA_WIDTH-1:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]             wr_ptr;
    logic [AW-1:0]             rd_ptr;
    logic [CNT_W-1:0]          count;
    logic                      push;
    logic                      pop;
    logic                      fifo_nonempty;
    logic [DATA_WIDTH-1:0]     fifo_head;

    state_t                    state;
    state_t                    state_nxt;
    logic                      tx_nxt;
    logic                      load_frame;
    logic                      reload;
    logic                      shift_en;
    logic                      stop_adv;
    logic                      bit_done;

    logic [DATA_WIDTH-1:0]     shift_reg;
    logic [IDX_W-1:0]          data_idx;
    logic [PRESCALE_WIDTH-1:0] bit_cnt;
    logic [PRESCALE_WIDTH-1:0] presc_q;
    logic [PRESCALE_WIDTH-1:0] presc_eff;
    logic                      par_en_q;
    logic                      two_stop_q;
    logic                      par_bit;
    logic                      stop_second;

    // ready is a function of the registered count only, so a pop while full
    // does not open the FIFO until the next cycle.
    assign ready         = (count != FULL_CNT);
    assign push          = Data_Valid && ready;
    assign fifo_nonempty = (count != '0);
    assign fifo_head     = mem[rd_ptr];
    assign presc_eff     = (prescale == '0) ? PRE_ONE : prescale;
    assign bit_done      = (bit_cnt == '0);
    assign busy          = (state != S_IDLE);

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= P_DATA;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= Data_Valid && !ready;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        state_nxt  = state;
        tx_nxt     = TX_OUT;
        pop        = 1'b0;
        load_frame = 1'b0;
        reload     = 1'b0;
        shift_en   = 1'b0;
        stop_adv   = 1'b0;
        case (state)
            S_IDLE: begin
                tx_nxt = 1'b1;
                if (fifo_nonempty) begin
                    pop        = 1'b1;
                    load_frame = 1'b1;
                    state_nxt  = S_START;
                    tx_nxt     = 1'b0;
                end
            end
            S_START: begin
                if (bit_done) begin
                    reload    = 1'b1;
                    state_nxt = S_DATA;
                    tx_nxt    = shift_reg[0];
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    reload = 1'b1;
                    if (data_idx == LAST_IDX) begin
                        if (par_en_q) begin
                            state_nxt = S_PARITY;
                            tx_nxt    = par_bit;
                        end else begin
                            state_nxt = S_STOP;
                            tx_nxt    = 1'b1;
                        end
                    end else begin
                        shift_en = 1'b1;
                        tx_nxt   = shift_reg[1];
                    end
                end
            end
            S_PARITY: begin
                if (bit_done) begin
                    reload    = 1'b1;
                    state_nxt = S_STOP;
                    tx_nxt    = 1'b1;
                end
            end
            S_STOP: begin
                if (bit_done) begin
                    if (two_stop_q && !stop_second) begin
                        reload   = 1'b1;
                        stop_adv = 1'b1;
                        tx_nxt   = 1'b1;
                    end else if (fifo_nonempty) begin
                        // back-to-back frame: no idle bit between stop and start
                        pop        = 1'b1;
                        load_frame = 1'b1;
                        state_nxt  = S_START;
                        tx_nxt     = 1'b0;
                    end else begin
                        state_nxt = S_IDLE;
                        tx_nxt    = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
                tx_nxt    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= S_IDLE;
            TX_OUT      <= 1'b1;
            shift_reg   <= '0;
            data_idx    <= '0;
            bit_cnt     <= '0;
            presc_q     <= '0;
            par_en_q    <= 1'b0;
            two_stop_q  <= 1'b0;
            par_bit     <= 1'b0;
            stop_second <= 1'b0;
        end else begin
            state  <= state_nxt;
            TX_OUT <= tx_nxt;
            if (load_frame) begin
                shift_reg   <= fifo_head;
                data_idx    <= '0;
                presc_q     <= presc_eff;
                bit_cnt     <= presc_eff - PRE_ONE;
                par_en_q    <= parity_enable;
                two_stop_q  <= two_stop;
                par_bit     <= (^fifo_head) ^ parity_type;
                stop_second <= 1'b0;
            end else begin
                if (reload) begin
                    bit_cnt <= presc_q - PRE_ONE;
                end else if (state != S_IDLE && !bit_done) begin
                    bit_cnt <= bit_cnt - PRE_ONE;
                end
                if (shift_en) begin
                    shift_reg <= shift_reg >> 1;
                    data_idx  <= data_idx + IDX_ONE;
                end
                if (stop_adv) begin
                    stop_second <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_buf.sv
// Testbench for uart_tx_buf: table vectors, hand-written corner sequences and
// randomized bursts checked against a frame-level line model.
module tb_uart_tx_buf;

    localparam int DW = 8;
    localparam int FD = 4;
    localparam int PW = 8;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic [DW-1:0] P_DATA = '0;
    logic          Data_Valid = 1'b0;
    logic          ready;
    logic          parity_enable = 1'b0;
    logic          parity_type = 1'b0;
    logic          two_stop = 1'b0;
    logic [PW-1:0] prescale = 8'd1;
    logic          TX_OUT;
    logic          busy;
    logic          overflow;

    uart_tx_buf #(
        .DATA_WIDTH    (DW),
        .FIFO_DEPTH    (FD),
        .PRESCALE_WIDTH(PW)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .P_DATA       (P_DATA),
        .Data_Valid   (Data_Valid),
        .ready        (ready),
        .parity_enable(parity_enable),
        .parity_type  (parity_type),
        .two_stop     (two_stop),
        .prescale     (prescale),
        .TX_OUT       (TX_OUT),
        .busy         (busy),
        .overflow     (overflow)
    );

    always #5 CLK = ~CLK;

    int   n_pass  = 0;
    int   n_total = 0;
    bit   exp_q[$];
    logic got_q[$];
    logic [DW-1:0] push_q[$];
    int   ovf_cnt = 0;
    int   busy_starts = 0;
    int   low_cnt = 0;
    bit   mon_en = 1'b0;
    logic prev_busy = 1'b0;

    typedef struct {
        logic [7:0] data;
        bit         pe;
        bit         pt;
        bit         ts;
        int         ps;
        int         exp_len;
        int         exp_par;
    } vec_t;

    vec_t vt[7];

    // line monitor: records TX_OUT on every busy cycle
    always @(negedge CLK) begin
        if (mon_en) begin
            if (busy === 1'b1) got_q.push_back(TX_OUT);
            if (busy === 1'b1 && prev_busy !== 1'b1) busy_starts++;
            if (overflow === 1'b1) ovf_cnt++;
            if (TX_OUT !== 1'b1) low_cnt++;
        end
        prev_busy = busy;
    end

    task automatic check(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    // reference: the line waveform of one frame, one entry per clock cycle
    task automatic model_frame(input logic [DW-1:0] d, input bit pe, input bit pt,
                               input bit ts, input int ps);
        int bp;
        bit fb[$];
        bp = (ps == 0) ? 1 : ps;
        fb.push_back(1'b0);
        for (int i = 0; i < DW; i++) fb.push_back(d[i]);
        if (pe) fb.push_back((^d) ^ pt);
        fb.push_back(1'b1);
        if (ts) fb.push_back(1'b1);
        foreach (fb[i]) begin
            for (int r = 0; r < bp; r++) exp_q.push_back(fb[i]);
        end
    endtask

    task automatic set_cfg(input bit pe, input bit pt, input bit ts, input int ps);
        parity_enable = pe;
        parity_type   = pt;
        two_stop      = ts;
        prescale      = PW'(ps);
    endtask

    task automatic start_mon();
        got_q.delete();
        exp_q.delete();
        ovf_cnt     = 0;
        busy_starts = 0;
        low_cnt     = 0;
        mon_en      = 1'b1;
    endtask

    task automatic push_burst();
        foreach (push_q[i]) begin
            @(negedge CLK);
            P_DATA     = push_q[i];
            Data_Valid = 1'b1;
        end
        @(negedge CLK);
        Data_Valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int bound);
        int c;
        c = 0;
        while (!(busy_starts > 0 && busy === 1'b0) && c < bound) begin
            @(negedge CLK);
            c++;
        end
        check({name, "_done"}, (c < bound) ? 1 : 0, 1);
        @(negedge CLK);
        mon_en = 1'b0;
    endtask

    task automatic compare_wave(input string name);
        int mism;
        int n;
        mism = 0;
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) mism++;
        check({name, "_len"}, got_q.size(), exp_q.size());
        check({name, "_wave"}, mism, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1, 10, 0};
        vt[1] = '{8'h07, 1'b1, 1'b0, 1'b0, 1, 11, 1};
        vt[2] = '{8'h07, 1'b1, 1'b1, 1'b0, 1, 11, 0};
        vt[3] = '{8'h3C, 1'b1, 1'b0, 1'b1, 4, 48, 0};
        vt[4] = '{8'hA5, 1'b0, 1'b0, 1'b0, 0, 10, 0};
        vt[5] = '{8'h00, 1'b1, 1'b1, 1'b0, 3, 33, 1};
        vt[6] = '{8'hFF, 1'b0, 1'b0, 1'b1, 2, 22, 0};

        #12;
        check("rst_tx", int'(TX_OUT), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_ready", int'(ready), 1);
        check("rst_ovf", int'(overflow), 0);
        @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);

        // table vectors: one frame each, config scrambled mid-frame
        for (int i = 0; i < 7; i++) begin
            int bp;
            string nm;
            nm = $sformatf("tbl%0d", i);
            bp = (vt[i].ps == 0) ? 1 : vt[i].ps;
            set_cfg(vt[i].pe, vt[i].pt, vt[i].ts, vt[i].ps);
            start_mon();
            model_frame(vt[i].data, vt[i].pe, vt[i].pt, vt[i].ts, vt[i].ps);
            push_q.delete();
            push_q.push_back(vt[i].data);
            push_burst();
            @(negedge CLK);
            set_cfg(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), $urandom_range(0, 7));
            wait_idle(nm, 500);
            compare_wave(nm);
            check({nm, "_tbl_len"}, got_q.size(), vt[i].exp_len);
            check({nm, "_starts"}, busy_starts, 1);
            if (vt[i].pe) begin
                int pb;
                pb = (got_q.size() > 9 * bp) ? int'(got_q[9 * bp]) : -1;
                check({nm, "_parity"}, pb, vt[i].exp_par);
            end
            if (i == 0) begin
                int v;
                v = 0;
                for (int b = 0; b < 10 && b < got_q.size(); b++) v |= int'(got_q[b]) << b;
                check("a5_bits", v, 'h34A);
            end
        end

        // six back-to-back pushes into a depth-4 FIFO while idle
        set_cfg(1'b0, 1'b0, 1'b0, 1);
        start_mon();
        for (int w = 0; w < 6; w++) begin
            @(negedge CLK);
            if (w == 0) check("burst_ready_empty", int'(ready), 1);
            if (w == 5) check("burst_ready_full", int'(ready), 0);
            P_DATA     = DW'(8'h11 * (w + 1));
            Data_Valid = 1'b1;
        end
        @(negedge CLK);
        Data_Valid = 1'b0;
        for (int w = 0; w < 5; w++) model_frame(DW'(8'h11 * (w + 1)), 1'b0, 1'b0, 1'b0, 1);
        wait_idle("burst6", 2000);
        compare_wave("burst6");
        check("burst6_ovf", ovf_cnt, 1);
        check("burst6_starts", busy_starts, 1);

        // reset in data bit 3 with two words queued
        set_cfg(1'b0, 1'b0, 1'b0, 2);
        start_mon();
        push_q.delete();
        push_q.push_back(8'h5A);
        push_q.push_back(8'hC3);
        push_q.push_back(8'h81);
        push_burst();
        for (int c = 0; c < 200 && got_q.size() < 9; c++) @(negedge CLK);
        check("rst_reach_bit3", (got_q.size() >= 9) ? 1 : 0, 1);
        #2;
        RST = 1'b0;
        #1;
        check("arst_tx", int'(TX_OUT), 1);
        check("arst_busy", int'(busy), 0);
        check("arst_ready", int'(ready), 1);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        start_mon();
        repeat (100) @(negedge CLK);
        mon_en = 1'b0;
        check("post_rst_low", low_cnt, 0);
        check("post_rst_starts", busy_starts, 0);

        // randomized bursts against the frame model
        for (int it = 0; it < 12; it++) begin
            int k;
            bit pe;
            bit pt;
            bit ts;
            int ps;
            logic [DW-1:0] d;
            k  = $urandom_range(1, 5);
            pe = 1'($urandom_range(0, 1));
            pt = 1'($urandom_range(0, 1));
            ts = 1'($urandom_range(0, 1));
            ps = $urandom_range(0, 5);
            set_cfg(pe, pt, ts, ps);
            start_mon();
            push_q.delete();
            for (int j = 0; j < k; j++) begin
                d = DW'($urandom);
                push_q.push_back(d);
                model_frame(d, pe, pt, ts, ps);
            end
            push_burst();
            wait_idle($sformatf("rnd%0d", it), 3000);
            compare_wave($sformatf("rnd%0d", it));
            check($sformatf("rnd%0d_ovf", it), ovf_cnt, 0);
            check($sformatf("rnd%0d_starts", it), busy_starts, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
